data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between NUM_REQ requesters (req 0 = core LSU, req 1 = debug/loader).
//  Grants one request per cycle, drives the memory request interface and routes each response back in order.
//  Tracks in-flight accesses in an ID FIFO; memory returns exactly one rvalid per granted access, reads and writes alike.
//  Sits between ex_stage LSU data_mem_* outputs and the data memory; requesters stall until granted.
// PARAMETERS
//  NUM_REQ    2   number of requesters (2..4)
//  ADDR_W     32  address width
//  DATA_W     32  data width; byte enables are DATA_W/8
//  MAX_OUTST  2   max in-flight accesses (ID FIFO depth, >=1)
//  ARB_MODE   1   0 = fixed priority (lower index wins), 1 = round robin
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  synchronous active-high reset
//  req_i        in   NUM_REQ            per-requester access request, held until gnt_o
//  lock_i       in   NUM_REQ            owner keeps port for back-to-back accesses (misaligned split)
//  addr_i       in   NUM_REQ*ADDR_W     per-requester address, flattened, req k at [k*ADDR_W +: ADDR_W]
//  we_i         in   NUM_REQ            per-requester write enable
//  be_i         in   NUM_REQ*DATA_W/8   per-requester byte enables
//  wdata_i      in   NUM_REQ*DATA_W     per-requester write data
//  gnt_o        out  NUM_REQ            one-hot grant, same cycle as request
//  rvalid_o     out  NUM_REQ            one-hot response valid to owner of the oldest access
//  rdata_o      out  DATA_W             mem_rdata_i broadcast to all requesters
//  mem_req_o    out  1                  memory request
//  mem_addr_o   out  ADDR_W             memory address
//  mem_we_o     out  1                  memory write enable
//  mem_be_o     out  DATA_W/8           memory byte enables
//  mem_wdata_o  out  DATA_W             memory write data
//  mem_rvalid_i in   1                  memory response valid (>=1 cycle after mem_req_o)
//  mem_rdata_i  in   DATA_W             memory read data
//  busy_o       out  1                  at least one access in flight
//  err_o        out  1                  sticky: rvalid received with no access in flight
// BEHAVIOUR
//  - Reset: FIFO empty, rr pointer = NUM_REQ-1 (req 0 wins first), lock owner cleared, err_o=0.
//    All outputs 0 while rst=1 and the cycle after; a reset mid-access discards in-flight IDs, late rvalid sets err_o.
//  - can_issue = FIFO not full OR mem_rvalid_i this cycle (pop and push in the same cycle allowed).
//  - Grant (combinational): if !can_issue, no grant. Else if lock owner valid and req_i[owner], grant owner.
//    Else ARB_MODE=0: lowest index with req_i. ARB_MODE=1: first requester after rr pointer, wrapping modulo NUM_REQ.
//  - mem_req_o = |gnt_o; mem_addr/we/be/wdata muxed from granted requester; all zero when no grant.
//  - On grant (clock edge): push owner ID; rr pointer <= granted index;
//    lock owner <= granted index if lock_i[granted], else cleared. Owner dropping req_i also clears the lock.
//  - Response: mem_rvalid_i with FIFO non-empty -> rvalid_o[head ID]=1, pop. With FIFO empty -> rvalid_o=0, err_o<=1.
//  - Responses return in grant order; no reordering; rdata_o = mem_rdata_i (combinational).
//  - busy_o = FIFO non-empty. Requester must hold req/addr/we/be/wdata stable until gnt_o.
//  - Grant-to-mem_req latency 0 cycles; rvalid_o latency = memory latency.
// STRUCTURE
//  - Add arb_mode_t {ARB_FIXED, ARB_RR} to riscv_defines; ARB_MODE takes its encoding.
//  - Sub-module arb_id_fifo: sync FIFO, width $clog2(NUM_REQ) (min 1), depth MAX_OUTST.
//    Simultaneous push/pop, full/empty flags, pointers wrap at MAX_OUTST.
//  - Top level holds grant logic, rr pointer, lock owner, muxes, err flag.
// TESTING
//  - Single req0 read addr 0x100, 1-cycle memory -> gnt_o=01 same cycle, next cycle rvalid_o=01, rdata_o=mem data.
//  - req0 and req1 held 4 cycles, ARB_MODE=1 -> grants 01,10,01,10; ARB_MODE=0 -> 01 every cycle.
//  - MAX_OUTST=2, 3-cycle memory latency, req1 continuous -> two grants, then gnt_o=0 until rvalid.
//    Grant in the same cycle as rvalid (pop+push).
//  - req0 with lock_i=1 for two accesses (misaligned word at 0x102) while req1 requests -> req0 granted twice, then req1.
//  - mem_rvalid_i pulse with FIFO empty -> rvalid_o=00, err_o=1 until rst; assert rst with 2 in flight -> busy_o=0 next cycle.
//  - Write req1 be=4'b0011 wdata=0xDEADBEEF -> mem_we_o=1, mem_be_o=0011, mem_wdata_o matches, rvalid_o=10 returns.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package data_mem_arbiter_pkg;

   // Arbitration policy; the encoding is the value of the ARB_MODE parameter.
   typedef enum logic {
      ARB_FIXED = 1'b0,  // lower requester index always wins
      ARB_RR    = 1'b1   // round robin starting after the last winner
   } arb_mode_t;

   // Width of a requester ID; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_id_fifo.sv
// In-flight access tracker: remembers which requester owns each outstanding
// memory access, oldest at the head. Push and pop may happen in the same cycle.
module arb_id_fifo #(
   parameter int ID_W  = 1,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic [ID_W-1:0] head_id,
   output logic            empty,
   output logic            full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ID_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head_id = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // ID storage write port.
   // NOTE: storage is deliberately not reset; entries are only read once the count says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between NUM_REQ requesters: combinational grant,
// request mux, in-order response routing through an ID FIFO, sticky error flag.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int        NUM_REQ   = 2,
   parameter int        ADDR_W    = 32,
   parameter int        DATA_W    = 32,
   parameter int        MAX_OUTST = 2,
   parameter arb_mode_t ARB_MODE  = ARB_RR
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            lock_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
   input  logic [NUM_REQ-1:0]            we_i,
   input  logic [NUM_REQ*DATA_W/8-1:0]   be_i,
   input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            rvalid_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic                          mem_req_o,
   output logic [ADDR_W-1:0]             mem_addr_o,
   output logic                          mem_we_o,
   output logic [DATA_W/8-1:0]           mem_be_o,
   output logic [DATA_W-1:0]             mem_wdata_o,
   input  logic                          mem_rvalid_i,
   input  logic [DATA_W-1:0]             mem_rdata_i,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int ID_W = id_width(NUM_REQ);

   logic            rst_q;      // reset was asserted last cycle
   logic            out_en;     // outputs are live (not in reset or the cycle after)
   logic [ID_W-1:0] rr_ptr;     // last granted requester
   logic            lock_vld;
   logic [ID_W-1:0] lock_own;
   logic            err_q;
   logic            can_issue;
   logic            gnt_vld;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] head_id;
   logic            fifo_empty;
   logic            fifo_full;

   assign out_en = !rst && !rst_q;

   arb_id_fifo #(
      .ID_W  (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (gnt_vld),
      .push_id (gnt_idx),
      .pop     (mem_rvalid_i),
      .head_id (head_id),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Grant selection: lock owner first, then fixed priority or round robin.
   // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      can_issue = !fifo_full || mem_rvalid_i;
      if (out_en && can_issue) begin
         if (lock_vld && req_i[lock_own]) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_own;
         end else if (ARB_MODE == ARB_FIXED) begin
            // Walk from lowest to highest priority; the last hit wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
               cand = ID_W'(k);
               if (req_i[cand]) begin
                  gnt_vld = 1'b1;
                  gnt_idx = cand;
               end
            end
         end else begin
            // Offset 1 after the last winner has highest priority, so visit it last.
            for (int off = NUM_REQ; off >= 1; off--) begin
               cand = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
               if (req_i[cand]) begin
                  gnt_vld = 1'b1;
                  gnt_idx = cand;
               end
            end
         end
      end
   end

   // Memory request mux and one-hot grant/response vectors.
   always_comb begin
      gnt_o       = '0;
      rvalid_o    = '0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (gnt_vld) gnt_o[gnt_idx] = 1'b1;
      if (out_en && mem_rvalid_i && !fifo_empty) rvalid_o[head_id] = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_vld && gnt_idx == ID_W'(k)) begin
            mem_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
            mem_we_o    = we_i[k];
            mem_be_o    = be_i[k*BE_W +: BE_W];
            mem_wdata_o = wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign mem_req_o = gnt_vld;
   assign rdata_o   = out_en ? mem_rdata_i : '0;
   assign busy_o    = out_en && !fifo_empty;
   assign err_o     = out_en && err_q;

   // Remember reset for one cycle so outputs stay quiet right after it.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Arbitration history, lock ownership and the sticky orphan-response flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= ID_W'(NUM_REQ - 1);
         lock_vld <= 1'b0;
         lock_own <= '0;
         err_q    <= 1'b0;
      end else begin
         if (gnt_vld) begin
            rr_ptr   <= gnt_idx;
            lock_vld <= lock_i[gnt_idx];
            lock_own <= gnt_idx;
         end else if (lock_vld && !req_i[lock_own]) begin
            lock_vld <= 1'b0;
         end
         if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin and a fixed-priority instance,
// each driven by its own requesters and memory, compared every cycle against
// a queue-based model, plus directed scenarios with literal expectations.
module tb_data_mem_arbiter;
   import data_mem_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;
   localparam int NI = 2;   // instance 0 = round robin, instance 1 = fixed priority

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req [NI];
   logic [N-1:0]    lock [NI];
   logic [N-1:0]    we [NI];
   logic [N*AW-1:0] addr [NI];
   logic [N*BW-1:0] be [NI];
   logic [N*DW-1:0] wdata [NI];
   logic            mem_rvalid [NI];
   logic [DW-1:0]   mem_rdata [NI];
   logic [N-1:0]    gnt [NI];
   logic [N-1:0]    rvalid [NI];
   logic [DW-1:0]   rdata [NI];
   logic            mem_req [NI];
   logic [AW-1:0]   mem_addr [NI];
   logic            mem_we [NI];
   logic [BW-1:0]   mem_be [NI];
   logic [DW-1:0]   mem_wdata [NI];
   logic            busy [NI];
   logic            err [NI];

   data_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .ARB_MODE(ARB_RR)) u_rr (
      .clk(clk), .rst(rst), .req_i(req[0]), .lock_i(lock[0]), .addr_i(addr[0]), .we_i(we[0]),
      .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
      .mem_req_o(mem_req[0]), .mem_addr_o(mem_addr[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
      .mem_wdata_o(mem_wdata[0]), .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0]),
      .busy_o(busy[0]), .err_o(err[0]));

   data_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .ARB_MODE(ARB_FIXED)) u_fx (
      .clk(clk), .rst(rst), .req_i(req[1]), .lock_i(lock[1]), .addr_i(addr[1]), .we_i(we[1]),
      .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
      .mem_req_o(mem_req[1]), .mem_addr_o(mem_addr[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
      .mem_wdata_o(mem_wdata[1]), .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1]),
      .busy_o(busy[1]), .err_o(err[1]));

   int checks = 0;
   int errors = 0;

   // Reference model state: owners of in-flight accesses, oldest first.
   int fq [NI][8];
   int fcnt [NI];
   int last_win [NI];
   int lock_own [NI];
   bit err_m [NI];
   bit hold_m = 1'b1;
   int gsel [NI];
   int cyc = 0;

   // Memory and requester agents.
   bit auto_mem = 1'b0;
   bit auto_req = 1'b0;
   int lat_min = 1;
   int lat_max = 1;
   int due [NI][8];
   int dcnt [NI];

   task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc%0d got %h expected %h", name, inst, cyc, act, exp);
      end
   endtask

   function automatic int model_grant(input int i);
      if (rst || hold_m) return -1;
      if (!(fcnt[i] < MO || mem_rvalid[i])) return -1;
      if (lock_own[i] >= 0 && req[i][lock_own[i]]) return lock_own[i];
      if (i == 1) begin
         for (int k = 0; k < N; k++) if (req[i][k]) return k;
      end else begin
         for (int off = 1; off <= N; off++) if (req[i][(last_win[i] + off) % N]) return (last_win[i] + off) % N;
      end
      return -1;
   endfunction

   // Compare every DUT output with the model, away from the rising edge.
   task automatic check_cycle();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         int  g;
         bit  z;
         logic [N-1:0] eg, er;
         g = model_grant(i);
         gsel[i] = g;
         z = rst || hold_m;
         eg = '0;
         er = '0;
         if (g >= 0) eg[g] = 1'b1;
         if (!z && mem_rvalid[i] && fcnt[i] > 0) er[fq[i][0]] = 1'b1;
         check("gnt", i, gnt[i], eg);
         check("mem_req", i, mem_req[i], g >= 0);
         check("mem_addr", i, mem_addr[i], (g >= 0) ? addr[i][g*AW +: AW] : '0);
         check("mem_we", i, mem_we[i], (g >= 0) ? we[i][g] : 1'b0);
         check("mem_be", i, mem_be[i], (g >= 0) ? be[i][g*BW +: BW] : '0);
         check("mem_wdata", i, mem_wdata[i], (g >= 0) ? wdata[i][g*DW +: DW] : '0);
         check("rvalid", i, rvalid[i], er);
         check("rdata", i, rdata[i], z ? '0 : mem_rdata[i]);
         check("busy", i, busy[i], !z && fcnt[i] > 0);
         check("err", i, err[i], !z && err_m[i]);
      end
   endtask

   task automatic new_txn(input int i, input int k);
      req[i][k]            = 1'b1;
      lock[i][k]           = ($urandom_range(0, 3) == 0);
      we[i][k]             = $urandom_range(0, 1);
      be[i][k*BW +: BW]    = BW'($urandom);
      addr[i][k*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
      wdata[i][k*DW +: DW] = $urandom;
   endtask

   // Advance the model across the rising edge, then drive the next cycle's inputs.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            fcnt[i] = 0; last_win[i] = N - 1; lock_own[i] = -1; err_m[i] = 1'b0; dcnt[i] = 0;
         end else begin
            if (mem_rvalid[i]) begin
               if (fcnt[i] > 0) begin
                  for (int j = 0; j < fcnt[i] - 1; j++) fq[i][j] = fq[i][j+1];
                  fcnt[i]--;
               end else begin
                  err_m[i] = 1'b1;
               end
            end
            if (gsel[i] >= 0) begin
               if (fcnt[i] < 8) begin fq[i][fcnt[i]] = gsel[i]; fcnt[i]++; end
               last_win[i] = gsel[i];
               lock_own[i] = lock[i][gsel[i]] ? gsel[i] : -1;
               if (auto_mem && dcnt[i] < 8) begin
                  int d;
                  d = cyc + $urandom_range(lat_min, lat_max);
                  if (dcnt[i] > 0 && d <= due[i][dcnt[i]-1]) d = due[i][dcnt[i]-1] + 1;
                  due[i][dcnt[i]] = d;
                  dcnt[i]++;
               end
            end else if (lock_own[i] >= 0 && !req[i][lock_own[i]]) begin
               lock_own[i] = -1;
            end
         end
      end
      hold_m = rst;
      cyc++;
      #1;
      for (int i = 0; i < NI; i++) begin
         if (auto_mem) begin
            mem_rdata[i]  = $urandom;
            mem_rvalid[i] = (dcnt[i] > 0 && due[i][0] == cyc);
            if (mem_rvalid[i]) begin
               for (int j = 0; j < dcnt[i] - 1; j++) due[i][j] = due[i][j+1];
               dcnt[i]--;
            end
         end
         if (auto_req) begin
            for (int k = 0; k < N; k++) begin
               if (gsel[i] == k) begin
                  if ($urandom_range(0, 1) == 1) new_txn(i, k);
                  else begin req[i][k] = 1'b0; lock[i][k] = 1'b0; end
               end else if (!req[i][k] && $urandom_range(0, 2) == 0) begin
                  new_txn(i, k);
               end
            end
         end
      end
   endtask

   task automatic cycle();
      check_cycle();
      tick();
   endtask

   task automatic set_req(input int k, input bit on, input bit lk, input logic [31:0] a,
                          input bit w, input logic [3:0] b, input logic [31:0] d);
      for (int i = 0; i < NI; i++) begin
         req[i][k] = on; lock[i][k] = lk; we[i][k] = w;
         addr[i][k*AW +: AW] = a; be[i][k*BW +: BW] = b; wdata[i][k*DW +: DW] = d;
      end
   endtask

   task automatic clear_reqs();
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic set_rvalid(input bit v, input logic [31:0] d);
      for (int i = 0; i < NI; i++) begin mem_rvalid[i] = v; mem_rdata[i] = d; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   initial begin
      logic [1:0] exp_rr [4];
      logic [1:0] exp_lat [4];
      exp_rr  = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_lat = '{2'b10, 2'b10, 2'b00, 2'b10};
      for (int i = 0; i < NI; i++) begin
         fcnt[i] = 0; last_win[i] = N - 1; lock_own[i] = -1; err_m[i] = 1'b0; dcnt[i] = 0; gsel[i] = -1;
      end
      clear_reqs();
      set_rvalid(1'b0, 32'h0);

      // Single read at 0x100, 1-cycle memory; requests are ignored in reset and the cycle after.
      set_req(0, 1'b1, 1'b0, 32'h100, 1'b0, 4'hF, 32'h0);
      check_cycle(); check("pin_rst_gnt", 0, gnt[0], 2'b00); tick();
      cycle();
      rst = 1'b0;
      check_cycle(); check("pin_hold_gnt", 0, gnt[0], 2'b00); tick();
      check_cycle(); check("pin_t1_gnt", 0, gnt[0], 2'b01); check("pin_t1_addr", 0, mem_addr[0], 32'h100); tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      set_rvalid(1'b1, 32'hCAFE_F00D);
      check_cycle(); check("pin_t1_rvalid", 0, rvalid[0], 2'b01); check("pin_t1_rdata", 0, rdata[0], 32'hCAFE_F00D); tick();
      set_rvalid(1'b0, 32'h0);

      // Both requesters held for four cycles, 1-cycle memory.
      do_reset();
      auto_mem = 1'b1; lat_min = 1; lat_max = 1;
      set_req(0, 1'b1, 1'b0, 32'h1000, 1'b0, 4'hF, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h2000, 1'b0, 4'hF, 32'h0);
      for (int c = 0; c < 4; c++) begin
         check_cycle(); check("pin_rr_gnt", 0, gnt[0], exp_rr[c]); check("pin_fx_gnt", 1, gnt[1], 2'b01); tick();
      end
      clear_reqs();
      repeat (4) cycle();

      // Outstanding limit with 3-cycle memory: two grants, stall, grant alongside the first response.
      do_reset();
      lat_min = 3; lat_max = 3;
      set_req(1, 1'b1, 1'b0, 32'h3000, 1'b0, 4'hF, 32'h0);
      for (int c = 0; c < 4; c++) begin
         check_cycle(); check("pin_outst_gnt", 0, gnt[0], exp_lat[c]); tick();
      end
      clear_reqs();
      repeat (8) cycle();

      // Locked misaligned pair from req0 while req1 waits.
      do_reset();
      lat_min = 1; lat_max = 1;
      set_req(0, 1'b1, 1'b1, 32'h100, 1'b0, 4'hC, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h300, 1'b0, 4'hF, 32'h0);
      check_cycle(); check("pin_lock_g0", 0, gnt[0], 2'b01); tick();
      set_req(0, 1'b1, 1'b0, 32'h104, 1'b0, 4'h3, 32'h0);
      check_cycle(); check("pin_lock_g1", 0, gnt[0], 2'b01); check("pin_lock_addr", 0, mem_addr[0], 32'h104); tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      check_cycle(); check("pin_lock_g2", 0, gnt[0], 2'b10); tick();
      clear_reqs();
      repeat (4) cycle();

      // Orphan response, then reset with two accesses in flight and a late response.
      do_reset();
      auto_mem = 1'b0;
      set_rvalid(1'b1, 32'h1234_5678);
      check_cycle(); check("pin_orphan_rvalid", 0, rvalid[0], 2'b00); tick();
      set_rvalid(1'b0, 32'h0);
      check_cycle(); check("pin_err_set", 0, err[0], 1'b1); tick();
      set_req(0, 1'b1, 1'b0, 32'h400, 1'b0, 4'hF, 32'h0);
      cycle(); cycle();
      clear_reqs();
      check_cycle(); check("pin_busy2", 0, busy[0], 1'b1); check("pin_err_sticky", 0, err[0], 1'b1); tick();
      rst = 1'b1;
      check_cycle(); check("pin_rst_busy", 0, busy[0], 1'b0); check("pin_rst_err", 0, err[0], 1'b0); tick();
      rst = 1'b0;
      check_cycle(); check("pin_after_rst_busy", 0, busy[0], 1'b0); tick();
      set_rvalid(1'b1, 32'h0);
      check_cycle(); check("pin_late_rvalid", 0, rvalid[0], 2'b00); tick();
      set_rvalid(1'b0, 32'h0);
      check_cycle(); check("pin_late_err", 0, err[0], 1'b1); tick();

      // Partial write from req1.
      do_reset();
      set_req(1, 1'b1, 1'b0, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      check_cycle();
      check("pin_wr_gnt", 0, gnt[0], 2'b10); check("pin_wr_we", 0, mem_we[0], 1'b1);
      check("pin_wr_be", 0, mem_be[0], 4'b0011); check("pin_wr_data", 0, mem_wdata[0], 32'hDEAD_BEEF);
      tick();
      clear_reqs();
      set_rvalid(1'b1, 32'h0);
      check_cycle(); check("pin_wr_rvalid", 0, rvalid[0], 2'b10); tick();
      set_rvalid(1'b0, 32'h0);

      // Randomized traffic with random memory latency.
      do_reset();
      auto_mem = 1'b1; lat_min = 1; lat_max = 3; auto_req = 1'b1;
      repeat (3000) cycle();
      auto_req = 1'b0;
      clear_reqs();
      repeat (12) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
